// File: rtl/dmem_block_mover_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_block_mover_if                                           |
// | Purpose  : Data-memory load/store port shared by the block mover and RAM |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface dmem_block_mover_if #(
  parameter int AW = 8
) ();
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_block_mover.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_block_mover                                              |
// | Purpose  : Ascending byte block copy src->dst over the data-memory port. |
// |            DMEM_BLOCK_MOVER_FILL_EN adds a constant-fill mode.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_block_mover #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
`ifdef DMEM_BLOCK_MOVER_FILL_EN
  input  logic          fill,
  input  logic [7:0]    fill_val,
`endif
  output logic          busy,
  output logic          done,
  dmem_block_mover_if.master bus
);

  localparam logic [AW:0] c_IDX_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_srcAddr;
  logic [AW-1:0] r_dstAddr;
  logic [AW:0]   r_len;
  logic [AW:0]   r_idx;
  logic [7:0]    r_hold;
  logic [AW:0]   w_idxNext;
  logic          w_startFill;
  logic          w_fill;
  logic [7:0]    w_fillVal;

`ifdef DMEM_BLOCK_MOVER_FILL_EN
  logic          r_fill;
  logic [7:0]    r_fillVal;

  assign w_startFill = fill;
  assign w_fill      = r_fill;
  assign w_fillVal   = r_fillVal;
`else
  assign w_startFill = 1'b0;
  assign w_fill      = 1'b0;
  assign w_fillVal   = 8'h00;
`endif

  // Counter is AW+1 bits so a full 2**AW move terminates on the compare.
  assign w_idxNext = r_idx + c_IDX_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_srcAddr <= '0;
      r_dstAddr <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_hold    <= 8'h00;
`ifdef DMEM_BLOCK_MOVER_FILL_EN
      r_fill    <= 1'b0;
      r_fillVal <= 8'h00;
`endif
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_srcAddr <= src_addr;
            r_dstAddr <= dst_addr;
            r_len     <= len;
            r_idx     <= '0;
`ifdef DMEM_BLOCK_MOVER_FILL_EN
            r_fill    <= fill;
            r_fillVal <= fill_val;
`endif
          end
        end
        S_RD:    r_hold <= bus.mem_rdata;
        S_WR:    r_idx  <= w_idxNext;
        default: r_idx  <= '0;
      endcase
    end
  end

  always_comb begin
    w_nextState   = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)       w_nextState = S_DONE;
          else if (w_startFill) w_nextState = S_WR;
          else                  w_nextState = S_RD;
        end
      end
      S_RD: begin
        busy         = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = r_srcAddr + r_idx[AW-1:0];
        w_nextState  = S_WR;
      end
      S_WR: begin
        busy          = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = r_dstAddr + r_idx[AW-1:0];
        bus.mem_wdata = w_fill ? w_fillVal : r_hold;
        if (w_idxNext == r_len) w_nextState = S_DONE;
        else if (w_fill)        w_nextState = S_WR;
        else                    w_nextState = S_RD;
      end
      default: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_block_mover.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_block_mover                                           |
// | Purpose  : Scoreboard bench for dmem_block_mover with a 256-byte memory. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dmem_block_mover;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] srcAddr = 8'h00;
  logic [7:0] dstAddr = 8'h00;
  logic [8:0] len = 9'h000;
  logic       fill = 1'b0;
  logic [7:0] fillVal = 8'h00;
  logic       busy;
  logic       done;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  wr_t        expWr[$];
  int         expDone[$];
  int         cyc = 0;
  int         rdCount = 0;
  int         nCompared = 0;
  int         nMismatched = 0;
  int         tStart = 0;

  dmem_block_mover_if #(.AW(8)) bus ();

  dmem_block_mover #(.AW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (srcAddr),
    .dst_addr (dstAddr),
    .len      (len),
`ifdef DMEM_BLOCK_MOVER_FILL_EN
    .fill     (fill),
    .fill_val (fillVal),
`endif
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : 8'h00;
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes and done times whenever the DUT presents them.
  always @(negedge clk) begin
    if (bus.mem_rd) rdCount++;
    if (bus.mem_rd && bus.mem_wr) check("rd_wr_exclusive", 32'd1, 32'd0);
    if (bus.mem_wr) begin
      if (expWr.size() == 0) check("unexpected_write", {16'h0, bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = expWr.pop_front();
        check("wr_addr", {24'h0, bus.mem_addr}, {24'h0, e.a});
        check("wr_data", {24'h0, bus.mem_wdata}, {24'h0, e.d});
      end
    end
    if (done) begin
      if (expDone.size() == 0) check("unexpected_done", cyc, 32'hFFFF_FFFF);
      else check("done_cycle", cyc, expDone.pop_front());
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    mem[a]   = v;
    model[a] = v;
  endtask

  task automatic doMove(input logic [7:0] s, input logic [7:0] d, input int n,
                        input logic f, input logic [7:0] fv);
    @(negedge clk);
    start = 1'b1; srcAddr = s; dstAddr = d; len = n[8:0]; fill = f; fillVal = fv;
    @(posedge clk);
    #1 start = 1'b0;
    tStart = cyc;
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = d + i[7:0];
      e.d = f ? fv : model[s + i[7:0]];
      model[e.a] = e.d;
      expWr.push_back(e);
    end
    expDone.push_back(tStart + (f ? n : 2 * n));
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (expDone.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (expDone.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      expDone.delete();
      expWr.delete();
    end
    #1;
  endtask

  task automatic checkQuiet(input string name);
    check({name, "_ctl"}, {28'h0, busy, done, bus.mem_rd, bus.mem_wr}, 32'h0);
    check({name, "_addr"}, {24'h0, bus.mem_addr}, 32'h0);
    check({name, "_wdata"}, {24'h0, bus.mem_wdata}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [6];
    int rd0;
    pat[0] = 8'h80; pat[1] = 8'hFF; pat[2] = 8'h16;
    pat[3] = 8'h7F; pat[4] = 8'hE0; pat[5] = 8'h01;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'h00;
      model[i] = 8'h00;
    end

    // Reset with random inputs
    start = 1'b1; srcAddr = 8'($urandom); dstAddr = 8'($urandom); len = 9'($urandom_range(1, 9));
    repeat (3) @(posedge clk);
    #1 checkQuiet("reset");
    @(negedge clk) start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkQuiet("post_reset");

    // Basic copy
    for (int i = 0; i < 6; i++) poke(8'd17 + i[7:0], pat[i]);
    doMove(8'd17, 8'd40, 6, 1'b0, 8'h00);
    waitIdle(40);
    for (int i = 0; i < 6; i++) begin
      check("copy_dst", {24'h0, mem[40 + i]}, {24'h0, pat[i]});
      check("copy_src", {24'h0, mem[17 + i]}, {24'h0, pat[i]});
    end

    // Zero length
    rd0 = rdCount;
    doMove(8'd1, 8'd2, 0, 1'b0, 8'h00);
    check("len0_busy_done", {30'h0, busy, done}, 32'h3);
    waitIdle(10);
    check("len0_busy_after", {31'h0, busy}, 32'h0);
    check("len0_no_reads", rdCount, rd0);

    // Overlapping dst>src replicates the first byte
    poke(8'd60, 8'h11); poke(8'd61, 8'h22); poke(8'd62, 8'h33);
    doMove(8'd60, 8'd61, 4, 1'b0, 8'h00);
    waitIdle(40);
    for (int i = 61; i < 65; i++) check("overlap", {24'h0, mem[i]}, 32'h11);

    // Address wrap
    poke(8'd254, 8'hAA); poke(8'd255, 8'hBB); poke(8'd0, 8'hCC); poke(8'd1, 8'hDD);
    doMove(8'd254, 8'd3, 4, 1'b0, 8'h00);
    waitIdle(40);
    check("wrap_3", {24'h0, mem[3]}, 32'hAA);
    check("wrap_4", {24'h0, mem[4]}, 32'hBB);
    check("wrap_5", {24'h0, mem[5]}, 32'hCC);
    check("wrap_6", {24'h0, mem[6]}, 32'hDD);

    // Full-memory move onto itself
    doMove(8'd5, 8'd5, 256, 1'b0, 8'h00);
    waitIdle(600);
    for (int i = 0; i < 256; i++)
      if (mem[i] !== model[i]) check("full_self", {24'h0, mem[i]}, {24'h0, model[i]});
    check("full_self_40", {24'h0, mem[40]}, 32'h80);

    // Start while busy is ignored
    doMove(8'd17, 8'd80, 6, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; srcAddr = 8'd0; dstAddr = 8'd0; len = 9'd1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_during_ignored", {31'h0, busy}, 32'h1);
    waitIdle(40);
    repeat (20) @(posedge clk);
    for (int i = 0; i < 6; i++) check("ignored_dst", {24'h0, mem[80 + i]}, {24'h0, pat[i]});

`ifdef DMEM_BLOCK_MOVER_FILL_EN
    rd0 = rdCount;
    doMove(8'd0, 8'd100, 3, 1'b1, 8'h5A);
    waitIdle(20);
    check("fill_no_reads", rdCount, rd0);
    for (int i = 100; i < 103; i++) check("fill_dst", {24'h0, mem[i]}, 32'h5A);
`endif

    // Reset mid-copy: three bytes land, the rest stays untouched
    doMove(8'd17, 8'd200, 6, 1'b0, 8'h00);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkQuiet("abort");
    expWr.delete();
    expDone.delete();
    for (int i = 203; i < 206; i++) model[i] = 8'h00;
    for (int i = 0; i < 3; i++) check("abort_written", {24'h0, mem[200 + i]}, {24'h0, pat[i]});
    for (int i = 3; i < 6; i++) check("abort_untouched", {24'h0, mem[200 + i]}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 checkQuiet("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
